hilo_muldiv: RTL and testbench

Parametrised multi-cycle multiply / multiply-accumulate / divide unit for the execute stage. It owns the HI/LO-producing datapath: signed/unsigned multiply, MADD/MSUB accumulate into a forwarded HI/LO value, and iterative signed/unsigned divide. Execute issues a start pulse and holds the pipeline on `stallreq_o`. The unit returns a registered double-width result with a one-cycle `done_o` pulse, which execute forwards to the HI/LO write path.

---
 rtl/hilo_muldiv_pkg.sv | 41 ++++
 rtl/hilo_muldiv_if.sv | 32 +++
 rtl/hilo_div_core.sv | 74 +++++++
 rtl/hilo_muldiv.sv | 171 +++++++++++++++++
 tb/tb_hilo_muldiv.sv | 300 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hilo_muldiv_pkg.sv
// hilo_muldiv_pkg: op codes, FSM states and op-class helpers
// shared by the HI/LO multiply/divide unit and its divider core.
package hilo_muldiv_pkg;

  typedef enum logic [2:0] {
    MD_MULT  = 3'd0,
    MD_MULTU = 3'd1,
    MD_MADD  = 3'd2,
    MD_MADDU = 3'd3,
    MD_MSUB  = 3'd4,
    MD_MSUBU = 3'd5,
    MD_DIV   = 3'd6,
    MD_DIVU  = 3'd7
  } md_op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_MUL,
    S_ACC,
    S_DIV,
    S_DONE
  } md_state_e;

  // Even encodings are the signed flavours.
  function automatic logic is_signed(input logic [2:0] op);
    return ~op[0];
  endfunction

  function automatic logic is_div(input logic [2:0] op);
    return op[2:1] == 2'b11;
  endfunction

  function automatic logic is_acc(input logic [2:0] op);
    return (op[2:1] == 2'b01) | (op[2:1] == 2'b10);
  endfunction

  function automatic logic is_sub(input logic [2:0] op);
    return op[2:1] == 2'b10;
  endfunction

endpackage

// File: rtl/hilo_muldiv_if.sv
// hilo_muldiv_if: execute <-> HI/LO unit bundle. master = execute
// (start/op/operands/hilo/cancel), slave = unit (busy/stall/done/hi/lo/dz).
interface hilo_muldiv_if #(
  parameter int WIDTH = 32
);
  logic               start_i;
  logic [2:0]         op_i;
  logic [WIDTH-1:0]   opa_i;
  logic [WIDTH-1:0]   opb_i;
  logic [2*WIDTH-1:0] hilo_i;
  logic               cancel_i;
  logic               busy_o;
  logic               stallreq_o;
  logic               done_o;
  logic [WIDTH-1:0]   hi_o;
  logic [WIDTH-1:0]   lo_o;
  logic               div_zero_o;

  modport master (
    output start_i, op_i, opa_i, opb_i,
    output hilo_i, cancel_i,
    input  busy_o, stallreq_o, done_o,
    input  hi_o, lo_o, div_zero_o
  );

  modport slave (
    input  start_i, op_i, opa_i, opb_i,
    input  hilo_i, cancel_i,
    output busy_o, stallreq_o, done_o,
    output hi_o, lo_o, div_zero_o
  );
endinterface

// File: rtl/hilo_div_core.sv
// hilo_div_core: restoring radix-2 divider, one quotient bit per cycle.
// Ports: clk, rst, abort_i, start_i, sgn_i, a_i, b_i -> done_o, quo_o, rem_o.
module hilo_div_core #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             abort_i,
  input  logic             start_i,
  input  logic             sgn_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] quo_o,
  output logic [WIDTH-1:0] rem_o
);

  logic [CNT_W-1:0] cnt_q;
  logic             run_q;
  logic             qneg_q;
  logic             rneg_q;
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] div_q;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [WIDTH:0]   shift;
  logic [WIDTH:0]   trial;

  assign mag_a = (sgn_i & a_i[WIDTH-1]) ? -a_i : a_i;
  assign mag_b = (sgn_i & b_i[WIDTH-1]) ? -b_i : b_i;

  // Remainder stays below the divisor, so one extra bit
  // suffices; trial[WIDTH] set means the subtract failed.
  assign shift = {rem_q, quo_q[WIDTH-1]};
  assign trial = shift - {1'b0, div_q};

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= '0;
      run_q  <= 1'b0;
      qneg_q <= 1'b0;
      rneg_q <= 1'b0;
      rem_q  <= '0;
      quo_q  <= '0;
      div_q  <= '0;
    end else if (abort_i) begin
      run_q <= 1'b0;
    end else if (start_i) begin
      cnt_q  <= CNT_W'(WIDTH);
      run_q  <= 1'b1;
      qneg_q <= sgn_i & (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
      rneg_q <= sgn_i & a_i[WIDTH-1];
      rem_q  <= '0;
      quo_q  <= mag_a;
      div_q  <= mag_b;
    end else if (run_q) begin
      if (cnt_q != '0) begin
        rem_q <= trial[WIDTH] ? shift[WIDTH-1:0]
                              : trial[WIDTH-1:0];
        quo_q <= {quo_q[WIDTH-2:0], ~trial[WIDTH]};
        cnt_q <= cnt_q - CNT_W'(1);
      end else begin
        run_q <= 1'b0;
      end
    end
  end

  assign done_o = run_q & (cnt_q == '0);
  assign quo_o  = qneg_q ? -quo_q : quo_q;
  assign rem_o  = rneg_q ? -rem_q : rem_q;

endmodule

// File: rtl/hilo_muldiv.sv
// hilo_muldiv: multi-cycle MULT/MADD/MSUB/DIV unit producing {HI,LO}.
// Ports: clk, rst, bus (hilo_muldiv_if.slave). Divider: HILO_MULDIV_DIV_EN.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input logic           clk,
  input logic           rst,
  hilo_muldiv_if.slave  bus
);

  localparam int W2 = 2 * WIDTH;

  if (CNT_W < $clog2(WIDTH + 1)) begin : g_cnt_chk
    $error("CNT_W too narrow for WIDTH");
  end

  md_state_e        state_q;
  md_op_e           op_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic [W2-1:0]    hilo_q;
  logic [W2-1:0]    prod_q;
  logic [WIDTH-1:0] hi_q;
  logic [WIDTH-1:0] lo_q;
  logic             done_q;
  logic             dz_q;

  logic             idle;
  logic             accept;
  logic             sgn;
  logic             neg;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic [W2-1:0]    prod_mag;
  logic [W2-1:0]    prod_d;
  logic [W2-1:0]    acc_d;

  assign idle   = state_q == S_IDLE;
  assign accept = idle & bus.start_i & ~bus.cancel_i;

  assign sgn   = is_signed(op_q);
  assign neg   = sgn & (opa_q[WIDTH-1] ^ opb_q[WIDTH-1]);
  assign mag_a = (sgn & opa_q[WIDTH-1]) ? -opa_q : opa_q;
  assign mag_b = (sgn & opb_q[WIDTH-1]) ? -opb_q : opb_q;

  assign prod_mag = W2'(mag_a) * W2'(mag_b);
  assign prod_d   = neg ? -prod_mag : prod_mag;
  assign acc_d    = is_sub(op_q) ? hilo_q - prod_q
                                 : hilo_q + prod_q;

`ifdef HILO_MULDIV_DIV_EN
  logic             dv_start;
  logic             dv_done;
  logic [WIDTH-1:0] dv_quo;
  logic [WIDTH-1:0] dv_rem;

  assign dv_start = accept & is_div(bus.op_i) & (|bus.opb_i);

  hilo_div_core #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_div (
    .clk     (clk),
    .rst     (rst),
    .abort_i (bus.cancel_i),
    .start_i (dv_start),
    .sgn_i   (is_signed(bus.op_i)),
    .a_i     (bus.opa_i),
    .b_i     (bus.opb_i),
    .done_o  (dv_done),
    .quo_o   (dv_quo),
    .rem_o   (dv_rem)
  );
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= MD_MULT;
      opa_q   <= '0;
      opb_q   <= '0;
      hilo_q  <= '0;
      prod_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else if (bus.cancel_i) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (bus.start_i) begin
            op_q   <= md_op_e'(bus.op_i);
            opa_q  <= bus.opa_i;
            opb_q  <= bus.opb_i;
            hilo_q <= bus.hilo_i;
            if (!is_div(bus.op_i)) begin
              state_q <= S_MUL;
`ifdef HILO_MULDIV_DIV_EN
            end else if (|bus.opb_i) begin
              state_q <= S_DIV;
            end else begin
              hi_q    <= bus.opa_i;
              lo_q    <= '1;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
`else
            // No divider: report as div-zero so execute
            // can raise reserved-instruction.
            end else begin
              hi_q    <= '0;
              lo_q    <= '0;
              dz_q    <= 1'b1;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end
`endif
          end
        end
        S_MUL: begin
          prod_q <= prod_d;
          if (is_acc(op_q)) begin
            state_q <= S_ACC;
          end else begin
            {hi_q, lo_q} <= prod_d;
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_ACC: begin
          {hi_q, lo_q} <= acc_d;
          dz_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= S_DONE;
        end
        S_DIV: begin
`ifdef HILO_MULDIV_DIV_EN
          if (dv_done) begin
            hi_q    <= dv_rem;
            lo_q    <= dv_quo;
            dz_q    <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
`else
          state_q <= S_IDLE;
`endif
        end
        S_DONE:  state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.busy_o     = ~idle;
  assign bus.stallreq_o = accept | (~idle & (state_q != S_DONE));
  assign bus.done_o     = done_q;
  assign bus.hi_o       = hi_q;
  assign bus.lo_o       = lo_q;
  assign bus.div_zero_o = dz_q;

endmodule

// File: tb/tb_hilo_muldiv.sv
// tb_hilo_muldiv: table vectors, corner sequences and random ops
// against an arithmetic reference model of the HI/LO unit.
module tb_hilo_muldiv;

  localparam int W = 32;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  hilo_muldiv_if #(.WIDTH(W)) bus ();

  hilo_muldiv #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] hilo;
    logic [63:0] res;
    logic        dz;
    int          lat;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string nm,
                     input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [2:0] op,
                       input logic [31:0] a,
                       input logic [31:0] b,
                       input logic [63:0] hilo);
    bus.start_i = 1'b1;
    bus.op_i    = op;
    bus.opa_i   = a;
    bus.opb_i   = b;
    bus.hilo_i  = hilo;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (!bus.done_o && cyc < 100) begin
      step();
      cyc++;
    end
  endtask

  // Spec-level model: plain arithmetic on 64-bit values.
  function automatic void model(input logic [2:0] op,
                                input logic [31:0] a,
                                input logic [31:0] b,
                                input logic [63:0] hilo,
                                output logic [63:0] res,
                                output logic dz,
                                output int lat);
    longint      sa, sb;
    logic [63:0] ua, ub, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = op[0] ? ua * ub : 64'(sa * sb);
    dz = 1'b0;
    case (op)
      3'd0, 3'd1: begin res = p;        lat = 2; end
      3'd2, 3'd3: begin res = hilo + p; lat = 3; end
      3'd4, 3'd5: begin res = hilo - p; lat = 3; end
      default: begin
`ifdef HILO_MULDIV_DIV_EN
        if (b == 0) begin
          res = {a, 32'hFFFFFFFF};
          dz  = 1'b1;
          lat = 1;
        end else if (op[0]) begin
          res = {a % b, a / b};
          lat = W + 2;
        end else begin
          longint q, r;
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
          lat = W + 2;
        end
`else
        res = 64'd0;
        dz  = 1'b1;
        lat = 1;
`endif
      end
    endcase
  endfunction

  // Issue one op from IDLE; returns in the cycle after done_o.
  task automatic run_op(input string nm,
                        input logic [2:0] op,
                        input logic [31:0] a,
                        input logic [31:0] b,
                        input logic [63:0] hilo,
                        output logic [63:0] res,
                        output logic dz,
                        output int lat);
    issue(op, a, b, hilo);
    #1;
    chk({nm, " stall0"}, 64'(bus.stallreq_o), 64'd1);
    step();
    bus.start_i = 1'b0;
    wait_done(1, lat);
    res = {bus.hi_o, bus.lo_o};
    dz  = bus.div_zero_o;
    step();
    chk({nm, " idle"}, 64'(bus.busy_o), 64'd0);
  endtask

  logic [63:0] res, eres;
  logic        dz, edz;
  int          lat, elat, cyc;
  logic        seen;

  initial begin
    bus.start_i  = 1'b0;
    bus.op_i     = 3'd0;
    bus.opa_i    = '0;
    bus.opb_i    = '0;
    bus.hilo_i   = '0;
    bus.cancel_i = 1'b0;

    tbl[0]  = '{3'd0, 32'hFFFFFFFD, 32'd7, 64'd0,
                64'hFFFFFFFF_FFFFFFEB, 1'b0, 2};
    tbl[1]  = '{3'd1, 32'hFFFFFFFD, 32'd7, 64'd0,
                64'h00000006_FFFFFFEB, 1'b0, 2};
    tbl[2]  = '{3'd2, 32'd5, 32'd6, 64'h10,
                64'h2E, 1'b0, 3};
    tbl[3]  = '{3'd4, 32'd5, 32'd6, 64'h10,
                64'hFFFFFFFF_FFFFFFF2, 1'b0, 3};
    tbl[4]  = '{3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF, 64'd1,
                64'hFFFFFFFE_00000002, 1'b0, 3};
    tbl[5]  = '{3'd5, 32'd2, 32'd3, 64'd0,
                64'hFFFFFFFF_FFFFFFFA, 1'b0, 3};
    tbl[6]  = '{3'd6, 32'hFFFFFFF9, 32'd2, 64'd0,
                64'hFFFFFFFF_FFFFFFFD, 1'b0, 34};
    tbl[7]  = '{3'd7, 32'd7, 32'd2, 64'd0,
                64'h00000001_00000003, 1'b0, 34};
    tbl[8]  = '{3'd6, 32'h80000000, 32'hFFFFFFFF, 64'd0,
                64'h00000000_80000000, 1'b0, 34};
    tbl[9]  = '{3'd6, 32'd5, 32'd0, 64'd0,
                64'h00000005_FFFFFFFF, 1'b1, 1};
    tbl[10] = '{3'd7, 32'd5, 32'd0, 64'd0,
                64'h00000005_FFFFFFFF, 1'b1, 1};
    tbl[11] = '{3'd6, 32'd7, 32'hFFFFFFFE, 64'd0,
                64'h00000001_FFFFFFFD, 1'b0, 34};
`ifndef HILO_MULDIV_DIV_EN
    for (int i = 0; i < 12; i++) begin
      if (tbl[i].op[2:1] == 2'b11) begin
        tbl[i].res = 64'd0;
        tbl[i].dz  = 1'b1;
        tbl[i].lat = 1;
      end
    end
`endif

    repeat (3) step();
    rst = 1'b0;
    step();
    chk("rst busy", 64'(bus.busy_o), 64'd0);
    chk("rst stall", 64'(bus.stallreq_o), 64'd0);
    chk("rst done", 64'(bus.done_o), 64'd0);
    chk("rst dz", 64'(bus.div_zero_o), 64'd0);
    chk("rst hilo", {bus.hi_o, bus.lo_o}, 64'd0);

    for (int i = 0; i < 12; i++) begin
      run_op($sformatf("vec%0d", i), tbl[i].op, tbl[i].a,
             tbl[i].b, tbl[i].hilo, res, dz, lat);
      chk($sformatf("vec%0d res", i), res, tbl[i].res);
      chk($sformatf("vec%0d dz", i), 64'(dz), 64'(tbl[i].dz));
      chk($sformatf("vec%0d lat", i), 64'(lat), 64'(tbl[i].lat));
    end

    // Stray start during MADD must be ignored.
    issue(3'd2, 32'd5, 32'd6, 64'h10);
    step();
    issue(3'd0, 32'd100, 32'd100, 64'hDEAD);
    step();
    bus.start_i = 1'b0;
    wait_done(2, cyc);
    chk("stray lat", 64'(cyc), 64'd3);
    chk("stray res", {bus.hi_o, bus.lo_o}, 64'h2E);
    step();
    chk("stray idle", 64'(bus.busy_o), 64'd0);

    // Reset mid-operation.
    issue(3'd0, 32'd5, 32'd6, 64'd0);
    step();
    bus.start_i = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("mrst busy", 64'(bus.busy_o), 64'd0);
    chk("mrst stall", 64'(bus.stallreq_o), 64'd0);
    chk("mrst done", 64'(bus.done_o), 64'd0);
    chk("mrst dz", 64'(bus.div_zero_o), 64'd0);
    chk("mrst hilo", {bus.hi_o, bus.lo_o}, 64'd0);
    step();

    // Cancel mid-operation: no done, result retained.
    run_op("pre", 3'd1, 32'd3, 32'd4, 64'd0, res, dz, lat);
    chk("pre res", res, 64'd12);
    begin
      int cc;
`ifdef HILO_MULDIV_DIV_EN
      cc = 10;
      issue(3'd6, 32'd1000, 32'd7, 64'd0);
`else
      cc = 2;
      issue(3'd2, 32'd5, 32'd6, 64'd0);
`endif
      step();
      bus.start_i = 1'b0;
      seen = 1'b0;
      for (int c = 1; c < cc; c++) begin
        seen |= bus.done_o;
        step();
      end
      bus.cancel_i = 1'b1;
      seen |= bus.done_o;
      step();
      bus.cancel_i = 1'b0;
      seen |= bus.done_o;
      chk("cxl busy", 64'(bus.busy_o), 64'd0);
      chk("cxl nodone", 64'(seen), 64'd0);
      chk("cxl hilo", {bus.hi_o, bus.lo_o}, 64'd12);
      issue(3'd0, 32'hFFFFFFFD, 32'd7, 64'd0);
      step();
      bus.start_i = 1'b0;
      wait_done(1, cyc);
      chk("cxl mult lat", 64'(cyc), 64'd2);
      chk("cxl mult res", {bus.hi_o, bus.lo_o},
          64'hFFFFFFFF_FFFFFFEB);
      step();
    end

    // Cancel together with start in IDLE starts nothing.
    issue(3'd0, 32'd2, 32'd2, 64'd0);
    bus.cancel_i = 1'b1;
    #1;
    chk("cxs stall", 64'(bus.stallreq_o), 64'd0);
    step();
    bus.start_i  = 1'b0;
    bus.cancel_i = 1'b0;
    chk("cxs busy", 64'(bus.busy_o), 64'd0);

    // Randomised ops against the model.
    for (int i = 0; i < 150; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      logic [63:0] h;
      op = 3'($urandom_range(0, 7));
      a  = $urandom;
      b  = $urandom;
      h  = {$urandom, $urandom};
      case ($urandom_range(0, 9))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: b = 32'($urandom_range(1, 15));
        3: b = -32'($urandom_range(1, 15));
        default: ;
      endcase
      model(op, a, b, h, eres, edz, elat);
      run_op($sformatf("rnd%0d", i), op, a, b, h,
             res, dz, lat);
      chk($sformatf("rnd%0d op%0d res", i, op), res, eres);
      chk($sformatf("rnd%0d dz", i), 64'(dz), 64'(edz));
      chk($sformatf("rnd%0d lat", i), 64'(lat), 64'(elat));
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
